// File: rtl/wb_ram_slave_pkg.sv
// Shared Wishbone definitions for the RAM slave and the CPU master bridge:
// bus widths, handshake FSM encoding and a byte-lane helper.
package wb_ram_slave_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_SELW = 4;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_ACK  = 2'd2
  } wb_state_e;

  function automatic logic [WB_SELW-1:0] lane_we(input logic en, input logic [WB_SELW-1:0] sel);
    return en ? sel : '0;
  endfunction

endpackage

// File: rtl/wb_ram_slave_if.sv
// Wishbone classic B3 bus bundle between the CPU master bridge and a slave.
interface wb_ram_slave_if;
  import wb_ram_slave_pkg::*;

  logic [WB_DW-1:0]   adr;
  logic [WB_DW-1:0]   wdat;
  logic [WB_DW-1:0]   rdat;
  logic               we;
  logic [WB_SELW-1:0] sel;
  logic               stb;
  logic               cyc;
  logic               ack;

  modport master (output adr, wdat, we, sel, stb, cyc, input rdat, ack);
  modport slave  (input adr, wdat, we, sel, stb, cyc, output rdat, ack);

endinterface

// File: rtl/wb_ram_slave_bytelane.sv
// Byte-lane RAM: 2**ADDR_WIDTH words of four independently writable bytes.
// Read data is registered and forced to zero on any cycle without a read.
module wb_ram_bytelane
  import wb_ram_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter              INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WB_SELW-1:0]    we,
  input  logic [WB_DW-1:0]      wdat,
  input  logic                  rd_en,
  output logic [WB_DW-1:0]      rdat
);

  logic [WB_SELW-1:0][7:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WB_SELW; i++) begin
      if (we[i]) mem[addr][i] <= wdat[8*i +: 8];
    end
    rdat <= rd_en ? mem[addr] : '0;
  end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave fronting an on-chip byte-lane RAM with optional wait
// states; accesses outside the RAM window are acked and flagged on oob_o.
module wb_ram_slave
  import wb_ram_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter              INIT_FILE   = ""
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  wb_ram_slave_if.slave wbs,
  output logic          oob_o
);

  localparam logic [WB_DW-1:0] WINDOW_BYTES = 32'd4 << ADDR_WIDTH;

  wb_state_e          state;
  logic [3:0]         wait_cnt;
  logic [WB_DW-1:0]   adr_q;
  logic [WB_DW-1:0]   dat_q;
  logic               we_q;
  logic [WB_SELW-1:0] sel_q;
  logic               hit_q;

  logic [WB_DW-1:0]   acc_adr;
  logic [WB_DW-1:0]   acc_dat;
  logic [WB_DW-1:0]   acc_off;
  logic               acc_we;
  logic [WB_SELW-1:0] acc_sel;
  logic               acc_hit;
  logic               acc_go;
  logic               req;

  // The RAM access happens on the edge that enters ACK. With no wait states
  // that is the sampling edge itself, so the live bus feeds the RAM in IDLE.
  always_comb begin
    req     = wbs.cyc && wbs.stb;
    acc_adr = (state == WB_IDLE) ? wbs.adr  : adr_q;
    acc_dat = (state == WB_IDLE) ? wbs.wdat : dat_q;
    acc_we  = (state == WB_IDLE) ? wbs.we   : we_q;
    acc_sel = (state == WB_IDLE) ? wbs.sel  : sel_q;
    acc_off = acc_adr - BASE_ADDR;
    acc_hit = (state == WB_IDLE) ? (acc_off < WINDOW_BYTES) : hit_q;
    acc_go  = !wb_rst_i &&
              (((state == WB_IDLE) && req && (WAIT_STATES == 0)) ||
               ((state == WB_WAIT) && wbs.cyc && (wait_cnt == '0)));
  end

  wb_ram_bytelane #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (wb_clk_i),
    .addr  (acc_off[ADDR_WIDTH+1:2]),
    .we    (lane_we(acc_go && acc_we && acc_hit, acc_sel)),
    .wdat  (acc_dat),
    .rd_en (acc_go && !acc_we && acc_hit),
    .rdat  (wbs.rdat)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= WB_IDLE;
      wait_cnt <= '0;
      wbs.ack  <= 1'b0;
      oob_o    <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      hit_q    <= 1'b0;
    end else begin
      wbs.ack <= 1'b0;
      oob_o   <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (req) begin
            adr_q <= wbs.adr;
            dat_q <= wbs.wdat;
            we_q  <= wbs.we;
            sel_q <= wbs.sel;
            hit_q <= acc_hit;
            if (WAIT_STATES > 0) begin
              state    <= WB_WAIT;
              wait_cnt <= 4'(WAIT_STATES - 1);
            end else begin
              state   <= WB_ACK;
              wbs.ack <= 1'b1;
              oob_o   <= !acc_hit;
            end
          end
        end
        WB_WAIT: begin
          if (!wbs.cyc) begin
            state <= WB_IDLE;
          end else if (wait_cnt == '0) begin
            state   <= WB_ACK;
            wbs.ack <= 1'b1;
            oob_o   <= !hit_q;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed and randomized bench for wb_ram_slave: a zero-wait instance at base 0
// and a three-wait instance at a non-zero base, both checked against a word model.
module tb_wb_ram_slave;

  localparam logic [31:0] BASE3 = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst;
  logic oob0, oob3;
  always #5 clk = ~clk;

  wb_ram_slave_if if0 ();
  wb_ram_slave_if if3 ();

  wb_ram_slave #(
    .ADDR_WIDTH  (10),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_STATES (0),
    .INIT_FILE   ("")
  ) dut0 (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (if0),
    .oob_o    (oob0)
  );

  wb_ram_slave #(
    .ADDR_WIDTH  (10),
    .BASE_ADDR   (BASE3),
    .WAIT_STATES (3),
    .INIT_FILE   ("")
  ) dut3 (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (if3),
    .oob_o    (oob3)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [2][1024];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int d);
    return (d == 0) ? if0.ack : if3.ack;
  endfunction
  function automatic logic [31:0] dat_of(input int d);
    return (d == 0) ? if0.rdat : if3.rdat;
  endfunction
  function automatic logic oob_of(input int d);
    return (d == 0) ? oob0 : oob3;
  endfunction
  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0 : BASE3;
  endfunction

  task automatic drive(input int d, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (d == 0) begin
      if0.cyc = cyc; if0.stb = stb; if0.we = we; if0.adr = adr; if0.wdat = dat; if0.sel = sel;
    end else begin
      if3.cyc = cyc; if3.stb = stb; if3.we = we; if3.adr = adr; if3.wdat = dat; if3.sel = sel;
    end
  endtask

  // One complete transfer; lat counts clock edges from the sampling edge to ack (0 = no ack).
  task automatic xfer(input int d, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd, output logic oob, output int lat);
    bit quiet = 1'b1;
    lat = 0;
    @(negedge clk);
    drive(d, 1'b1, 1'b1, we, adr, dat, sel);
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      if (ack_of(d) === 1'b1) begin
        lat = k;
        break;
      end
      if (dat_of(d) !== 32'h0 || oob_of(d) !== 1'b0) quiet = 1'b0;
      @(posedge clk); #1;
    end
    rd  = dat_of(d);
    oob = oob_of(d);
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    check("ack_single_cycle", 32'(ack_of(d)), 32'h0);
    check("dat_cleared_after_ack", dat_of(d), 32'h0);
    check("oob_cleared_after_ack", 32'(oob_of(d)), 32'h0);
    check("quiet_before_ack", 32'(quiet), 32'h1);
  endtask

  task automatic op(input int d, input logic we, input logic [31:0] off, input logic [31:0] dat,
                    input logic [3:0] sel, output logic [31:0] rd);
    logic oob;
    int   lat;
    logic hit;
    hit = (off < 32'h1000);
    xfer(d, we, base_of(d) + off, dat, sel, rd, oob, lat);
    check("latency", 32'(lat), (d == 0) ? 32'd1 : 32'd4);
    check("oob_flag", 32'(oob), 32'(!hit));
    if (!we) begin
      check("read_data", rd, hit ? model[d][off[11:2]] : 32'h0);
    end else if (hit) begin
      for (int b = 0; b < 4; b++)
        if (sel[b]) model[d][off[11:2]][8*b +: 8] = dat[8*b +: 8];
    end
  endtask

  task automatic b2b(input int d, input int edges, input int exp_acks);
    int acks = 0;
    int dbl = 0;
    int bad = 0;
    logic prev = 1'b0;
    @(negedge clk);
    drive(d, 1'b1, 1'b1, 1'b0, base_of(d) + 32'h10, '0, 4'hF);
    for (int e = 0; e < edges; e++) begin
      @(posedge clk); #1;
      if (ack_of(d) === 1'b1) begin
        acks++;
        if (prev) dbl++;
        if (dat_of(d) !== model[d][4]) bad++;
      end
      prev = ack_of(d);
    end
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (6) @(posedge clk);
    check("b2b_ack_count", 32'(acks), 32'(exp_acks));
    check("b2b_no_double_ack", 32'(dbl), 32'h0);
    check("b2b_read_data", 32'(bad), 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    int          acks;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // Idle after reset: nothing on either slave's outputs.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("reset_ack_oob", {28'h0, if0.ack, if3.ack, oob0, oob3}, 32'h0);
      check("reset_dat0", if0.rdat, 32'h0);
      check("reset_dat3", if3.rdat, 32'h0);
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++)
        op(d, 1'b1, 32'(i * 4), $urandom, 4'hF, rd);

    // Full word, then byte lanes, then an empty select.
    op(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd);
    op(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    check("full_word_read", rd, 32'hDEAD_BEEF);
    op(0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, rd);
    op(0, 1'b1, 32'h10, 32'h5500_0000, 4'b1000, rd);
    op(0, 1'b0, 32'h10, 32'h0, 4'h0, rd);
    check("byte_lane_merge", rd, 32'h55AD_BEAA);
    op(0, 1'b1, 32'h10, 32'h1234_5678, 4'h0, rd);
    op(0, 1'b0, 32'h10, 32'h0, 4'hF, rd);
    check("sel_zero_no_write", rd, 32'h55AD_BEAA);

    op(0, 1'b1, 32'hFFC, 32'hCAFE_F00D, 4'hF, rd);
    op(0, 1'b0, 32'hFFC, 32'h0, 4'hF, rd);
    check("last_word", rd, 32'hCAFE_F00D);

    // Wait-state slave: latency and cycle abort.
    op(1, 1'b1, 32'h0, 32'h0BAD_C0DE, 4'hF, rd);
    op(1, 1'b0, 32'h0, 32'h0, 4'hF, rd);
    check("wait_read", rd, 32'h0BAD_C0DE);
    op(1, 1'b1, 32'h4, 32'hA5A5_0001, 4'hF, rd);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b1, BASE3 + 32'h4, 32'hFFFF_FFFF, 4'hF);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (if3.ack === 1'b1) acks++;
    end
    check("abort_no_ack", 32'(acks), 32'h0);
    op(1, 1'b0, 32'h4, 32'h0, 4'hF, rd);
    check("abort_no_write", rd, 32'hA5A5_0001);

    // Out of window: above, and below the base of the offset slave.
    op(0, 1'b0, 32'h1000, 32'h0, 4'hF, rd);
    op(0, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, rd);
    op(0, 1'b0, 32'h0, 32'h0, 4'hF, rd);
    op(1, 1'b0, 32'h1000, 32'h0, 4'hF, rd);
    op(1, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, rd);
    op(1, 1'b1, 32'hFFFF_FFFC, 32'h8765_4321, 4'hF, rd);
    op(1, 1'b0, 32'h0, 32'h0, 4'hF, rd);
    check("oob_no_alias", rd, 32'h0BAD_C0DE);

    // Reset while a write is waiting: discarded.
    op(1, 1'b1, 32'h20, 32'h1111_2222, 4'hF, rd);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 1'b1, BASE3 + 32'h20, 32'h3333_4444, 4'hF);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("reset_in_wait_ack", 32'(if3.ack), 32'h0);
    @(negedge clk); rst = 1'b0;
    drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (if3.ack === 1'b1) acks++;
    end
    check("reset_in_wait_idle", 32'(acks), 32'h0);
    op(1, 1'b0, 32'h20, 32'h0, 4'hF, rd);
    check("reset_in_wait_data", rd, 32'h1111_2222);

    // Reset during ACK: the write already landed on the edge entering ACK.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h30, 32'h7777_8888, 4'hF);
    @(posedge clk); #1;
    check("ack_before_reset", 32'(if0.ack), 32'h1);
    @(negedge clk); rst = 1'b1;
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk); #1;
    check("reset_in_ack", 32'(if0.ack), 32'h0);
    @(negedge clk); rst = 1'b0;
    model[0][12] = 32'h7777_8888;
    op(0, 1'b0, 32'h30, 32'h0, 4'hF, rd);

    // Strobe held high: one ack per transfer with an idle bubble between.
    b2b(0, 12, 6);
    b2b(1, 20, 4);

    repeat (150) begin
      int          d;
      logic        we;
      logic [31:0] off;
      d   = int'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      off = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 1023) * 4)
                                        : 32'($urandom_range(0, 63) * 4);
      op(d, we, off, $urandom, 4'($urandom_range(0, 15)), rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
